// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I sequencing controller.
// State enum, opcode values and datapath mux-select constants.
package mctrl_pkg;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        sel = IMM_I;
        unique case (op)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            OP_LUI:    sel = IMM_U;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mctrl_perf_cnt.sv
// Cycle and retired-instruction counters for the multicycle controller.
// Both counters wrap modulo 2^CNT_W and clear on reset.
module mctrl_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cycle_en_i,
    input  logic             instret_en_i,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_o   <= '0;
            instret_o <= '0;
        end else begin
            if (cycle_en_i) begin
                cycle_o <= cycle_o + 1'b1;
            end
            if (instret_en_i) begin
                instret_o <= instret_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I sequencing controller: mux selects and write strobes.
// Define MCTRL_PERF_EN to add cycle_o/instret_o performance counters.
module multicycle_ctrl_fsm
    import mctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       op_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             reg_write_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [2:0]       imm_src_o,
    output logic [1:0]       result_src_o,
    output logic             illegal_o
`ifdef MCTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instret_o,
    output logic [CNT_W-1:0] cycle_o
`endif
);

    state_e state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_BOOT;
        end else begin
            unique case (state_q)
                S_BOOT: state_q <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready_i) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    unique case (op_i)
                        OP_LOAD,
                        OP_STORE:  state_q <= S_MEMADR;
                        OP_R:      state_q <= S_EXEC_R;
                        OP_I:      state_q <= S_EXEC_I;
                        OP_BRANCH: state_q <= S_BRANCH;
                        OP_JAL:    state_q <= S_JAL;
                        OP_LUI:    state_q <= S_LUI;
                        default:   state_q <= S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    if (op_i == OP_STORE) begin
                        state_q <= S_MEMWR;
                    end else begin
                        state_q <= S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    if (mem_ready_i) begin
                        state_q <= S_MEMWB;
                    end
                end
                S_MEMWR: begin
                    if (mem_ready_i) begin
                        state_q <= S_FETCH;
                    end
                end
                S_MEMWB:  state_q <= S_FETCH;
                S_EXEC_R: state_q <= S_ALUWB;
                S_EXEC_I: state_q <= S_ALUWB;
                S_ALUWB:  state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_JAL:    state_q <= S_ALUWB;
                S_LUI:    state_q <= S_ALUWB;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_TRAP;
            endcase
        end
    end

    // Strobes that hinge on mem_ready_i/zero_i are decoded combinationally
    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RS2;
        alu_op_o     = ALUOP_ADD;
        imm_src_o    = IMM_I;
        result_src_o = RES_ALUOUT;
        illegal_o    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_a_o  = SRCA_PC;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
                imm_src_o   = imm_sel(op_i);
            end
            S_MEMADR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                imm_src_o   = (op_i == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMRD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWB: begin
                result_src_o = RES_MEM;
                reg_write_o  = 1'b1;
            end
            S_MEMWR: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                adr_src_o   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_RS2;
                alu_op_o    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_FUNCT;
                imm_src_o   = IMM_I;
            end
            S_ALUWB: begin
                result_src_o = RES_ALUOUT;
                reg_write_o  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o  = SRCA_RS1;
                alu_src_b_o  = SRCB_RS2;
                alu_op_o     = ALUOP_SUB;
                result_src_o = RES_ALUOUT;
                pc_write_o   = zero_i;
            end
            S_JAL: begin
                alu_src_a_o  = SRCA_OLDPC;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALUOUT;
                pc_write_o   = 1'b1;
            end
            S_LUI: begin
                alu_src_a_o = SRCA_ZERO;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_PASSB;
                imm_src_o   = IMM_U;
            end
            S_TRAP: begin
                illegal_o = 1'b1;
            end
            default: begin
                illegal_o = 1'b0;
            end
        endcase
    end

`ifdef MCTRL_PERF_EN
    logic retire;

    // An instruction retires on the edge that returns the FSM to FETCH
    assign retire = (state_q == S_MEMWB)
                  | (state_q == S_ALUWB)
                  | (state_q == S_BRANCH)
                  | ((state_q == S_MEMWR) & mem_ready_i);

    // BOOT always exits after one cycle, so every post-reset edge counts
    mctrl_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cycle_en_i  (1'b1),
        .instret_en_i(retire),
        .cycle_o     (cycle_o),
        .instret_o   (instret_o)
    );
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: directed per-cycle output vectors.
// Counter checks are compiled in only when MCTRL_PERF_EN is defined.
module tb_multicycle_ctrl_fsm;

    localparam int CNT_W = 32;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [6:0]       op = 7'd0;
    logic             zero = 1'b0;
    logic             rdy = 1'b0;
    logic             mem_req, mem_write, adr_src;
    logic             ir_write, pc_write, reg_write;
    logic [1:0]       alu_a, alu_b, alu_op, res_src;
    logic [2:0]       imm_src;
    logic             illegal;
`ifdef MCTRL_PERF_EN
    logic [CNT_W-1:0] instret, cycles;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .op_i        (op),
        .zero_i      (zero),
        .mem_ready_i (rdy),
        .mem_req_o   (mem_req),
        .mem_write_o (mem_write),
        .adr_src_o   (adr_src),
        .ir_write_o  (ir_write),
        .pc_write_o  (pc_write),
        .reg_write_o (reg_write),
        .alu_src_a_o (alu_a),
        .alu_src_b_o (alu_b),
        .alu_op_o    (alu_op),
        .imm_src_o   (imm_src),
        .result_src_o(res_src),
        .illegal_o   (illegal)
`ifdef MCTRL_PERF_EN
        ,
        .instret_o   (instret),
        .cycle_o     (cycles)
`endif
    );

    typedef logic [17:0] vec_t;
    typedef struct {
        vec_t  v;
        string nm;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Field packing only: req,wr,adr,ir,pc,rw,a,b,op,imm,res,ill
    function automatic vec_t mk(
        input logic req, input logic wr, input logic adr,
        input logic ir, input logic pc, input logic rw,
        input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] aop, input logic [2:0] imm,
        input logic [1:0] res, input logic ill);
        return {req, wr, adr, ir, pc, rw, a, b, aop, imm, res, ill};
    endfunction

    function automatic vec_t e_boot();
        return '0;
    endfunction
    function automatic vec_t e_fetch(input logic go);
        return mk(1, 0, 0, go, go, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 0);
    endfunction
    function automatic vec_t e_decode(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 2'b00, 0);
    endfunction
    function automatic vec_t e_memadr(input logic [2:0] imm);
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 2'b00, 0);
    endfunction
    function automatic vec_t e_memrd();
        return mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic vec_t e_memwb();
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0);
    endfunction
    function automatic vec_t e_memwr();
        return mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic vec_t e_exec_r();
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
    endfunction
    function automatic vec_t e_exec_i();
        return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 3'b000, 2'b00, 0);
    endfunction
    function automatic vec_t e_aluwb();
        return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic vec_t e_branch(input logic z);
        return mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b01, 3'b000, 2'b00, 0);
    endfunction
    function automatic vec_t e_jal();
        return mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic vec_t e_lui();
        return mk(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b11, 3'b100, 2'b00, 0);
    endfunction
    function automatic vec_t e_trap();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
    endfunction

    task automatic step(input logic r, input logic z, input logic [6:0] o,
                        input vec_t e, input string nm);
        @(posedge clk);
        #1;
        rdy  = r;
        zero = z;
        op   = o;
        q.push_back('{v: e, nm: nm});
    endtask

    vec_t act;
    exp_t cur;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_a, alu_b, alu_op, imm_src, res_src, illegal};
            checks++;
            if (act !== cur.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", cur.nm, act, cur.v);
            end
        end
    end

    initial begin
        step(0, 0, RT, e_boot(), "reset_hold");
        step(0, 0, RT, e_boot(), "boot_release");
        rst_n = 1'b1;

        step(1, 0, RT, e_fetch(1), "r_fetch");
        step(1, 0, RT, e_decode(3'b000), "r_decode");
        step(1, 0, RT, e_exec_r(), "r_exec");
        step(1, 0, RT, e_aluwb(), "r_aluwb");

        step(1, 0, LD, e_fetch(1), "ld_fetch");
        step(1, 0, LD, e_decode(3'b000), "ld_decode");
        step(1, 0, LD, e_memadr(3'b000), "ld_memadr");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, LD, e_memrd(), "ld_memrd_wait");
        end
        step(1, 0, LD, e_memrd(), "ld_memrd_go");
        step(1, 0, LD, e_memwb(), "ld_memwb");

        step(0, 0, ST, e_fetch(0), "st_fetch_wait");
        step(1, 0, ST, e_fetch(1), "st_fetch");
        step(1, 0, ST, e_decode(3'b001), "st_decode");
        step(1, 0, ST, e_memadr(3'b001), "st_memadr");
        step(0, 0, ST, e_memwr(), "st_memwr_wait");
        step(1, 0, ST, e_memwr(), "st_memwr_go");

        step(1, 1, BR, e_fetch(1), "bt_fetch");
        step(1, 1, BR, e_decode(3'b010), "bt_decode");
        step(1, 1, BR, e_branch(1), "bt_branch_taken");
        step(1, 0, BR, e_fetch(1), "bn_fetch");
        step(1, 0, BR, e_decode(3'b010), "bn_decode");
        step(1, 0, BR, e_branch(0), "bn_branch_not");

        step(1, 0, JL, e_fetch(1), "jal_fetch");
        step(1, 0, JL, e_decode(3'b011), "jal_decode");
        step(1, 0, JL, e_jal(), "jal_exec");
        step(1, 0, JL, e_aluwb(), "jal_aluwb");

        step(1, 0, LU, e_fetch(1), "lui_fetch");
        step(1, 0, LU, e_decode(3'b100), "lui_decode");
        step(1, 0, LU, e_lui(), "lui_exec");
        step(1, 0, LU, e_aluwb(), "lui_aluwb");

        step(1, 0, IT, e_fetch(1), "i_fetch");
        step(1, 0, IT, e_decode(3'b000), "i_decode");
        step(1, 0, IT, e_exec_i(), "i_exec");
        step(1, 0, IT, e_aluwb(), "i_aluwb");

        step(1, 0, LD, e_fetch(1), "rst_ld_fetch");
        step(1, 0, LD, e_decode(3'b000), "rst_ld_decode");
        step(1, 0, LD, e_memadr(3'b000), "rst_ld_memadr");
        step(0, 0, LD, e_memrd(), "rst_ld_memrd");
        step(0, 0, LD, e_boot(), "rst_mid_memrd");
        rst_n = 1'b0;
        step(0, 0, LD, e_boot(), "rst_boot");
        rst_n = 1'b1;

        step(1, 0, BAD, e_fetch(1), "bad_fetch");
        step(1, 0, BAD, e_decode(3'b000), "bad_decode");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, BAD, e_trap(), "trap_held");
        end
        step(1, 0, BAD, e_boot(), "trap_reset");
        rst_n = 1'b0;
        step(1, 0, RT, e_boot(), "perf_boot");
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step(1, 0, RT, e_fetch(1), "perf_fetch");
            step(1, 0, RT, e_decode(3'b000), "perf_decode");
            step(1, 0, RT, e_exec_r(), "perf_exec");
            step(1, 0, RT, e_aluwb(), "perf_aluwb");
        end
        step(0, 0, RT, e_fetch(0), "perf_fetch3");
`ifdef MCTRL_PERF_EN
        checks++;
        if (instret !== 32'd3) begin
            errors++;
            $display("FAIL instret: got %0d expected 3", instret);
        end
        checks++;
        if (cycles !== 32'd13) begin
            errors++;
            $display("FAIL cycle: got %0d expected 13", cycles);
        end
`endif

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
